mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-master arbiter that shares the single mmu memory port between instruction fetch (i_*) and data access (d_*).
//  Serialises requests: one outstanding transaction at a time, with req/gnt/rvalid handshakes per master.
//  Drives mmu vaddr/data/byteena/memWE for exactly one cycle per transaction and returns q to the winning master.
//  Holds the mmu address at 0 when idle, so UART side-effect addresses (0x201 Tx write, 0x202 Rx read) are hit only once.
// PARAMETERS
//  RD_LATENCY  2  cycles from the issue cycle until mmu q is valid (>=1); the arbiter samples q at the end of issue+RD_LATENCY
// PORTS
//  clock      in   1   single clock for all logic
//  RST        in   1   synchronous, active-high reset
//  i_req      in   1   fetch read request; hold with i_addr stable until i_gnt
//  i_addr     in   32  fetch address
//  i_gnt      out  1   one-cycle pulse: fetch transaction issued this cycle
//  i_rvalid   out  1   one-cycle pulse: i_rdata valid
//  i_rdata    out  32  fetch read data, held until the next i_rvalid
//  d_req      in   1   data request; hold with d_addr, d_wdata, d_be and d_we stable until d_gnt
//  d_addr     in   32  data address
//  d_wdata    in   32  write data
//  d_be       in   4   byte enables for writes
//  d_we       in   1   1 = write, 0 = read
//  d_gnt      out  1   one-cycle pulse: data transaction issued this cycle
//  d_rvalid   out  1   one-cycle pulse: d_rdata valid (reads only)
//  d_rdata    out  32  data read result, held until the next d_rvalid
//  m_vaddr    out  32  to mmu vaddr
//  m_data     out  32  to mmu data
//  m_byteena  out  4   to mmu byteena
//  m_memWE    out  1   to mmu memWE
//  m_q        in   32  from mmu q
// BEHAVIOUR
//  - Reset and idle values: all gnt/rvalid = 0, rdata = 0, m_vaddr = 0, m_data = 0, m_byteena = 0, m_memWE = 0.
//  - All outputs are registered. FSM states: IDLE, ISSUE, WAIT.
//  - IDLE: sample requests. If any req is high: latch the winner, set owner, go to ISSUE on the next edge. Otherwise stay in IDLE.
//  - ISSUE (cycle T): m_* carry the winner's request and the winner's gnt = 1.
//      Fetch requests drive m_byteena = 4'hF and m_memWE = 0.
//      A write goes to IDLE at T+1 with no rvalid.
//      A read loads the counter with RD_LATENCY and goes to WAIT.
//  - In every cycle other than ISSUE, m_* return to their idle values.
//  - WAIT: decrement the counter each cycle. At the end of cycle T+RD_LATENCY, capture m_q into the owner's rdata.
//    The owner's rvalid = 1 during T+RD_LATENCY+1, which is also spent in IDLE.
//  - Throughput: a write every 2 cycles; a read every RD_LATENCY+2 cycles.
//  - A req dropped before gnt is a withdrawal and is never issued. A req held after gnt issues again.
//  - RST mid-transaction: back to IDLE next cycle, pending rvalid discarded, outputs at reset values.
//  - The arbiter ignores byte-enables and address decode; the mmu owns UART/RAM mapping.
// CONFIGURATION
//  - MEM_ARB_RR_EN undefined: fixed priority, d beats i whenever both are requesting in IDLE.
//  - MEM_ARB_RR_EN defined: round-robin.
//      A last-winner flag (reset value = i) is updated at each gnt.
//      When both request, the master that was not last granted wins. A lone requester always wins.
// TESTING
//  1. i_req with i_addr=0x40, model RAM[0x40]=0x12345678:
//     -> i_gnt at cycle 1; m_vaddr=0x40, m_byteena=F, m_memWE=0 for cycle 1 only; i_rvalid at cycle 4 (RD_LATENCY=2), i_rdata=0x12345678.
//  2. d write addr=0x100, data=0xDEADBEEF, be=0x3:
//     -> d_gnt with m_memWE=1, m_byteena=0x3 for one cycle; no d_rvalid; RAM[0x100] low half = 0xBEEF.
//  3. i_req and d_req both held high for 8 transactions:
//     -> fixed priority: 8 d grants, 0 i grants; with MEM_ARB_RR_EN: grants alternate d,i,d,i,...
//  4. d read 0x202 (UART Rx):
//     -> m_vaddr=0x202 for exactly one cycle, then 0; d_rdata = Rx byte zero-extended.
//  5. RST pulsed at T+1 of a read:
//     -> no rvalid ever asserted; all outputs 0 the following cycle; a new req is granted normally afterwards.
//  6. Back-to-back d writes with req held:
//     -> d_gnt every 2nd cycle; m_memWE never high in two consecutive cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter (fetch i_*, data d_*) serialising one transaction at a time onto the single mmu port.
// Define MEM_ARB_RR_EN for round-robin arbitration; by default data has fixed priority over fetch.
module mem_arbiter #(
    parameter int RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    input  logic        d_we,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] m_vaddr,
    output logic [31:0] m_data,
    output logic [3:0]  m_byteena,
    output logic        m_memWE,
    input  logic [31:0] m_q
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             owner_d_r, owner_d_nxt_s;
    logic             pick_d_s;
    logic             i_gnt_r, i_gnt_nxt_s;
    logic             d_gnt_r, d_gnt_nxt_s;
    logic             i_rvalid_r, i_rvalid_nxt_s;
    logic             d_rvalid_r, d_rvalid_nxt_s;
    logic [31:0]      i_rdata_r, i_rdata_nxt_s;
    logic [31:0]      d_rdata_r, d_rdata_nxt_s;
    logic [31:0]      m_vaddr_r, m_vaddr_nxt_s;
    logic [31:0]      m_data_r, m_data_nxt_s;
    logic [3:0]       m_byteena_r, m_byteena_nxt_s;
    logic             m_memWE_r, m_memWE_nxt_s;

`ifdef MEM_ARB_RR_EN
    logic last_d_r, last_d_nxt_s;

    // Winner select: on contention the master not granted last time wins.
    always_comb begin
        pick_d_s = d_req & (~i_req | ~last_d_r);
    end

    // Last-winner flag, starts out as fetch so data wins the first contention.
    always_ff @(posedge clock) begin
        if (RST) begin
            last_d_r <= 1'b0;
        end else begin
            last_d_r <= last_d_nxt_s;
        end
    end
`else
    // Winner select: data always beats fetch.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    // Next-state and next registered-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        owner_d_nxt_s   = owner_d_r;
        i_gnt_nxt_s     = 1'b0;
        d_gnt_nxt_s     = 1'b0;
        i_rvalid_nxt_s  = 1'b0;
        d_rvalid_nxt_s  = 1'b0;
        i_rdata_nxt_s   = i_rdata_r;
        d_rdata_nxt_s   = d_rdata_r;
        m_vaddr_nxt_s   = 32'd0;
        m_data_nxt_s    = 32'd0;
        m_byteena_nxt_s = 4'h0;
        m_memWE_nxt_s   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d_nxt_s    = last_d_r;
`endif
        case (state_r)
            IDLE: begin
                if (i_req | d_req) begin
                    state_nxt_s   = ISSUE;
                    owner_d_nxt_s = pick_d_s;
`ifdef MEM_ARB_RR_EN
                    last_d_nxt_s  = pick_d_s;
`endif
                    if (pick_d_s) begin
                        d_gnt_nxt_s     = 1'b1;
                        m_vaddr_nxt_s   = d_addr;
                        m_data_nxt_s    = d_wdata;
                        m_byteena_nxt_s = d_be;
                        m_memWE_nxt_s   = d_we;
                    end else begin
                        i_gnt_nxt_s     = 1'b1;
                        m_vaddr_nxt_s   = i_addr;
                        m_data_nxt_s    = 32'd0;
                        m_byteena_nxt_s = 4'hF;
                        m_memWE_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                // The registered write strobe tells us what kind of transaction is on the port.
                if (m_memWE_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = CNT_W'(RD_LATENCY);
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = IDLE;
                    if (owner_d_r) begin
                        d_rdata_nxt_s  = m_q;
                        d_rvalid_nxt_s = 1'b1;
                    end else begin
                        i_rdata_nxt_s  = m_q;
                        i_rvalid_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any read in flight.
    always_ff @(posedge clock) begin
        if (RST) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            owner_d_r   <= 1'b0;
            i_gnt_r     <= 1'b0;
            d_gnt_r     <= 1'b0;
            i_rvalid_r  <= 1'b0;
            d_rvalid_r  <= 1'b0;
            i_rdata_r   <= 32'd0;
            d_rdata_r   <= 32'd0;
            m_vaddr_r   <= 32'd0;
            m_data_r    <= 32'd0;
            m_byteena_r <= 4'h0;
            m_memWE_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            owner_d_r   <= owner_d_nxt_s;
            i_gnt_r     <= i_gnt_nxt_s;
            d_gnt_r     <= d_gnt_nxt_s;
            i_rvalid_r  <= i_rvalid_nxt_s;
            d_rvalid_r  <= d_rvalid_nxt_s;
            i_rdata_r   <= i_rdata_nxt_s;
            d_rdata_r   <= d_rdata_nxt_s;
            m_vaddr_r   <= m_vaddr_nxt_s;
            m_data_r    <= m_data_nxt_s;
            m_byteena_r <= m_byteena_nxt_s;
            m_memWE_r   <= m_memWE_nxt_s;
        end
    end

    assign i_gnt     = i_gnt_r;
    assign d_gnt     = d_gnt_r;
    assign i_rvalid  = i_rvalid_r;
    assign d_rvalid  = d_rvalid_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign m_vaddr   = m_vaddr_r;
    assign m_data    = m_data_r;
    assign m_byteena = m_byteena_r;
    assign m_memWE   = m_memWE_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int RL = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        RST;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_memWE;
    logic [31:0] i_rdata, d_rdata, m_vaddr, m_data, m_q;
    logic [3:0]  m_byteena;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int uart_hits = 0;

    mem_arbiter #(.RD_LATENCY(RL)) dut (
        .clock(clock), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_we(d_we),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_vaddr(m_vaddr), .m_data(m_data), .m_byteena(m_byteena), .m_memWE(m_memWE), .m_q(m_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // mmu model: word memory with byte-enable writes, UART Rx at 0x202, q valid RL cycles after issue
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h40) return 32'h1234_5678;
        else if (a == 32'h100) return 32'h1122_3344;
        else return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    logic [31:0]   mmu_ram [0:1023];
    logic [1023:0] mmu_wr = '0;
    logic [31:0]   qp [RL];

    function automatic logic [31:0] mmu_rd(input logic [31:0] a);
        if (a == 32'h202) return 32'h0000_00A5;
        else if (mmu_wr[a[11:2]]) return mmu_ram[a[11:2]];
        else return init_val(a);
    endfunction

    always @(posedge clock) begin
        if (RST) begin
            mmu_wr <= '0;
        end else if (m_memWE) begin
            mmu_ram[m_vaddr[11:2]] <= merge(mmu_rd(m_vaddr), m_data, m_byteena);
            mmu_wr[m_vaddr[11:2]] <= 1'b1;
        end
        qp[0] <= mmu_rd(m_vaddr);
        for (int k = 1; k < RL; k++) qp[k] <= qp[k-1];
        if (m_vaddr == 32'h202) uart_hits <= uart_hits + 1;
    end
    assign m_q = qp[RL-1];

    // Reference memory for the random phase, updated from intended transactions
    logic [31:0] ref_ram [0:1023];
    bit          ref_wr  [0:1023];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_wr[a[11:2]]) return ref_ram[a[11:2]];
        else return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_gnt(input bit want_d, output bit got);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (want_d ? d_gnt : i_gnt) got = 1'b1;
        end
        chk("gnt_timeout", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int t0, tg, h0;
        bit got, rv;
        h0 = uart_hits;
        if (v.is_d) begin
            d_req = 1'b1; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be; d_we = v.we;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        t0 = cyc;
        wait_gnt(v.is_d, got);
        if (got) begin
            tg = cyc;
            chk("gnt_latency", 32'(tg - t0), 32'd1);
            chk("other_gnt", 32'(v.is_d ? i_gnt : d_gnt), 32'd0);
            chk("m_vaddr", m_vaddr, v.addr);
            chk("m_data", m_data, v.exp_data);
            chk("m_byteena", 32'(m_byteena), 32'(v.exp_be));
            chk("m_memWE", 32'(m_memWE), 32'(v.exp_we));
            i_req = 1'b0;
            d_req = 1'b0;
            for (int k = 1; k <= RL + 3; k++) begin
                tick();
                if (k == 1) chk("m_idle_after_issue", m_vaddr | m_data | 32'(m_byteena) | 32'(m_memWE), 32'd0);
                rv = v.is_d ? d_rvalid : i_rvalid;
                chk("rvalid", 32'(rv), 32'((!v.we) && (k == RL + 1)));
                chk("wrong_rvalid", 32'(v.is_d ? i_rvalid : d_rvalid), 32'd0);
                if (rv) chk("rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
            end
            if (!v.we) chk("rdata_held", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
            chk("uart_hits", 32'(uart_hits - h0), 32'(v.addr == 32'h202));
        end else begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ngr, last_g, pend_due, free_at, tg;
        bit got, exp_d, prev_we, pi, pd, exp_any, win_d, last_d, pend_v, pend_d;
        logic [31:0] pend_data;

        RST = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'h0;

        //          is_d  we    addr          wdata          be    exp_data       exp_be exp_we exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        4'h0, 32'h0,         4'hF, 1'b0, 32'h1234_5678};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 32'hDEAD_BEEF, 4'h3, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'h0,         4'hF, 1'b0, 32'h1122_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0202, 32'h0,        4'h1, 32'h0,         4'h1, 1'b0, 32'h0000_00A5};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hC, 32'hCAFE_F00D, 4'hC, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'h0,         4'hF, 1'b0, 32'hCAFE_0300};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_00EE, 4'h1, 32'h0000_00EE, 4'h1, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        4'h0, 32'h0,         4'hF, 1'b0, 32'h1234_56EE};

        // Reset values
        repeat (3) tick();
        chk("reset_ctrl", {26'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, m_memWE, |m_byteena}, 32'd0);
        chk("reset_rdata", i_rdata | d_rdata, 32'd0);
        chk("reset_m", m_vaddr | m_data, 32'd0);
        RST = 1'b0;
        tick();

        for (int n = 0; n < 8; n++) run_vec(vecs[n]);

        // Both masters hold requests for 8 transactions
        RST = 1'b1; tick(); RST = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'd0;
        ngr = 0; last_g = 0;
        for (int k = 0; k < 100 && ngr < 8; k++) begin
            tick();
            if (i_gnt | d_gnt) begin
                chk("pri_single", 32'(i_gnt & d_gnt), 32'd0);
                exp_d = RR_EN ? ((ngr % 2) == 0) : 1'b1;
                chk("pri_order", 32'(d_gnt), 32'(exp_d));
                if (ngr > 0) chk("pri_read_spacing", 32'(cyc - last_g), 32'(RL + 2));
                last_g = cyc;
                ngr++;
            end
        end
        chk("pri_count", 32'(ngr), 32'd8);
        i_req = 1'b0; d_req = 1'b0;
        repeat (RL + 3) tick();

        // Reset in the cycle after a read issues
        d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0;
        wait_gnt(1'b1, got);
        d_req = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_ctrl", {26'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, m_memWE, |m_byteena}, 32'd0);
        chk("rst_mid_rdata", i_rdata | d_rdata, 32'd0);
        chk("rst_mid_m", m_vaddr | m_data, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_no_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
        end
        run_vec(vecs[0]);

        // Back-to-back writes with d_req held
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
        prev_we = 1'b0; ngr = 0; last_g = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("wr_memwe_consecutive", 32'(m_memWE & prev_we), 32'd0);
            prev_we = m_memWE;
            if (d_gnt) begin
                if (ngr > 0) chk("wr_spacing", 32'(cyc - last_g), 32'd2);
                last_g = cyc;
                ngr++;
            end
        end
        chk("wr_count", 32'(ngr), 32'd6);
        d_req = 1'b0;
        repeat (3) tick();

        // A fetch request withdrawn while a read is in flight is never issued
        d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0;
        wait_gnt(1'b1, got);
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h40;
        tick();
        i_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("withdraw_no_gnt", 32'(i_gnt), 32'd0);
        end

        // Randomized traffic against the transaction-level model
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        for (int a = 0; a < 1024; a++) ref_wr[a] = 1'b0;
        last_d = 1'b0; pend_v = 1'b0; pend_d = 1'b0; pend_due = 0; pend_data = 32'd0;
        free_at = cyc + 1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            pi = i_req;
            pd = d_req;
            exp_any = (cyc >= free_at) && (pi || pd);
            chk("rnd_gnt", 32'(i_gnt | d_gnt), 32'(exp_any));
            if ((i_gnt | d_gnt) && exp_any) begin
                win_d = RR_EN ? (pd && (!pi || !last_d)) : pd;
                chk("rnd_winner", {30'd0, d_gnt, i_gnt}, win_d ? 32'd2 : 32'd1);
                last_d = win_d;
                tg = cyc;
                if (win_d) begin
                    chk("rnd_d_vaddr", m_vaddr, d_addr);
                    chk("rnd_d_ctl", {m_data, 32'(m_byteena), 32'(m_memWE)} == {d_wdata, 32'(d_be), 32'(d_we)}, 32'd1);
                    if (d_we) begin
                        ref_ram[d_addr[11:2]] = merge(ref_rd(d_addr), d_wdata, d_be);
                        ref_wr[d_addr[11:2]] = 1'b1;
                        free_at = tg + 2;
                    end else begin
                        pend_v = 1'b1; pend_d = 1'b1; pend_due = tg + RL + 1;
                        pend_data = ref_rd(d_addr);
                        free_at = tg + RL + 2;
                    end
                    d_req = 1'b0;
                end else begin
                    chk("rnd_i_vaddr", m_vaddr, i_addr);
                    chk("rnd_i_ctl", {m_data, 32'(m_byteena), 32'(m_memWE)} == {32'd0, 32'hF, 32'd0}, 32'd1);
                    pend_v = 1'b1; pend_d = 1'b0; pend_due = tg + RL + 1;
                    pend_data = ref_rd(i_addr);
                    free_at = tg + RL + 2;
                    i_req = 1'b0;
                end
            end
            chk("rnd_i_rvalid", 32'(i_rvalid), 32'(pend_v && !pend_d && cyc == pend_due));
            chk("rnd_d_rvalid", 32'(d_rvalid), 32'(pend_v && pend_d && cyc == pend_due));
            if (pend_v && cyc == pend_due) begin
                chk("rnd_rdata", pend_d ? d_rdata : i_rdata, pend_data);
                pend_v = 1'b0;
            end
            if (c >= 1450) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end else begin
                if (!i_req && $urandom_range(0, 1) == 0) begin
                    i_req = 1'b1;
                    i_addr = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
                end else if (i_req && $urandom_range(0, 15) == 0) begin
                    i_req = 1'b0;
                end
                if (!d_req && $urandom_range(0, 1) == 0) begin
                    d_req = 1'b1;
                    d_addr = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
                    d_we = 1'($urandom_range(0, 1));
                    d_wdata = $urandom;
                    d_be = 4'($urandom_range(1, 15));
                end else if (d_req && $urandom_range(0, 15) == 0) begin
                    d_req = 1'b0;
                end
            end
        end
        chk("rnd_drained", 32'(pend_v), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
